// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - parametrised multi-cycle ALU: single-cycle logic/arith/shift, iterative MUL and restoring DIVU
module alu_iter #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_dz,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t               r_state;
    logic [SHW-1:0]       r_cnt;
    logic [WIDTH-1:0]     r_opnd;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_result;
    logic [WIDTH-1:0]     r_result_hi;
    logic                 r_flag_zero;
    logic                 r_flag_carry;
    logic                 r_flag_dz;

    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_sub;
    logic [SHW-1:0]       w_sh;
    logic [WIDTH-1:0]     w_res;
    logic [WIDTH-1:0]     w_res_hi;
    logic                 w_carry;
    logic                 w_dz;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_sh;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_div_next;
    logic                 w_last;

    assign w_sh = b[SHW-1:0];

    always_comb begin
        w_add    = {1'b0, a} + {1'b0, b};
        w_sub    = {1'b0, a} - {1'b0, b};
        w_res    = '0;
        w_res_hi = '0;
        w_carry  = 1'b0;
        w_dz     = 1'b0;
        case (opcode)
            4'h0: begin w_res = w_add[WIDTH-1:0]; w_carry = w_add[WIDTH]; end
            4'h1: begin w_res = w_sub[WIDTH-1:0]; w_carry = w_sub[WIDTH]; end
            4'h2: w_res = a & b;
            4'h3: w_res = a | b;
            4'h4: w_res = a ^ b;
            4'h5: w_res = ~(a | b);
            4'h6: w_res = a << w_sh;
            4'h7: w_res = ~(a ^ b);
            // Only reaches the output when b == 0; nonzero divisors go to S_DIV.
            4'h9: begin w_res = '1; w_res_hi = a; w_dz = 1'b1; end
            4'hA: w_res = a >> w_sh;
            4'hB: w_res = $unsigned($signed(a) >>> w_sh);
            default: ;
        endcase
    end

    // Multiply: {hi, multiplier} register; add multiplicand into hi when lsb set, then shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: {remainder, dividend/quotient}; shift left one bit, subtract divisor if it fits.
    assign w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_opnd};
    assign w_div_ge   = ~w_div_diff[WIDTH];
    assign w_div_next = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ge};

    assign w_last = (r_cnt == SHW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_opnd       <= '0;
            r_acc        <= '0;
            r_out_valid  <= 1'b0;
            r_result     <= '0;
            r_result_hi  <= '0;
            r_flag_zero  <= 1'b0;
            r_flag_carry <= 1'b0;
            r_flag_dz    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (opcode == 4'h8) begin
                            r_state <= S_MUL;
                            r_opnd  <= a;
                            r_acc   <= {{WIDTH{1'b0}}, b};
                            r_cnt   <= '0;
                        end else if (opcode == 4'h9 && b != '0) begin
                            r_state <= S_DIV;
                            r_opnd  <= b;
                            r_acc   <= {{WIDTH{1'b0}}, a};
                            r_cnt   <= '0;
                        end else begin
                            r_result     <= w_res;
                            r_result_hi  <= w_res_hi;
                            r_flag_zero  <= (w_res == '0);
                            r_flag_carry <= w_carry;
                            r_flag_dz    <= w_dz;
                            r_out_valid  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state      <= S_IDLE;
                        r_result     <= w_mul_next[WIDTH-1:0];
                        r_result_hi  <= w_mul_next[2*WIDTH-1:WIDTH];
                        r_flag_zero  <= (w_mul_next[WIDTH-1:0] == '0);
                        r_flag_carry <= 1'b0;
                        r_flag_dz    <= 1'b0;
                        r_out_valid  <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state      <= S_IDLE;
                        r_result     <= w_div_next[WIDTH-1:0];
                        r_result_hi  <= w_div_next[2*WIDTH-1:WIDTH];
                        r_flag_zero  <= (w_div_next[WIDTH-1:0] == '0);
                        r_flag_carry <= 1'b0;
                        r_flag_dz    <= 1'b0;
                        r_out_valid  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = ~in_ready;
    assign out_valid  = r_out_valid;
    assign result     = r_result;
    assign result_hi  = r_result_hi;
    assign flag_zero  = r_flag_zero;
    assign flag_carry = r_flag_carry;
    assign flag_dz    = r_flag_dz;

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - scoreboard bench for alu_iter at WIDTH=16 and WIDTH=8
module tb_alu_iter;

    typedef struct {
        logic [15:0] res;
        logic [15:0] hi;
        logic        z;
        logic        c;
        logic        dz;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] a16 = '0, b16 = '0;
    logic [3:0]  op16 = '0;
    logic        iv16 = 1'b0;
    logic        in_ready16, out_valid16, zero16, carry16, dz16, busy16;
    logic [15:0] result16, result_hi16;

    logic [7:0]  a8 = '0, b8 = '0;
    logic [3:0]  op8 = '0;
    logic        iv8 = 1'b0;
    logic        in_ready8, out_valid8, zero8, carry8, dz8, busy8;
    logic [7:0]  result8, result_hi8;

    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_iter #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .opcode(op16), .in_valid(iv16),
        .in_ready(in_ready16), .out_valid(out_valid16), .result(result16),
        .result_hi(result_hi16), .flag_zero(zero16), .flag_carry(carry16),
        .flag_dz(dz16), .busy(busy16)
    );

    alu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .opcode(op8), .in_valid(iv8),
        .in_ready(in_ready8), .out_valid(out_valid8), .result(result8),
        .result_hi(result_hi8), .flag_zero(zero8), .flag_carry(carry8),
        .flag_dz(dz8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid16) begin
            if (q16.size() == 0) begin
                check("unexpected_out_valid16", 32'd1, 32'd0);
            end else begin
                e16 = q16.pop_front();
                check("result16", {16'h0, result16}, {16'h0, e16.res});
                check("result_hi16", {16'h0, result_hi16}, {16'h0, e16.hi});
                check("flags16", {29'h0, zero16, carry16, dz16}, {29'h0, e16.z, e16.c, e16.dz});
                check("latency16", cyc, e16.due);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid8) begin
            if (q8.size() == 0) begin
                check("unexpected_out_valid8", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("result8", {24'h0, result8}, {24'h0, e8.res[7:0]});
                check("result_hi8", {24'h0, result_hi8}, {24'h0, e8.hi[7:0]});
                check("flags8", {29'h0, zero8, carry8, dz8}, {29'h0, e8.z, e8.c, e8.dz});
                check("latency8", cyc, e8.due);
            end
        end
    end

    task automatic drive(input logic [15:0] ta, input logic [15:0] tb, input logic [3:0] top,
                         input logic [15:0] er, input logic [15:0] eh,
                         input logic ez, input logic ec, input logic ed,
                         input int lat, input bit push);
        a16  = ta;
        b16  = tb;
        op16 = top;
        iv16 = 1'b1;
        if (push) q16.push_back('{er, eh, ez, ec, ed, cyc + 1 + lat});
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        iv16 = 1'b0;
        iv8  = 1'b0;
        n = 0;
        while (!(in_ready16 && in_ready8 && q16.size() == 0 && q8.size() == 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, (n < 100) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_outputs", {result16, result_hi16}, 32'h0);
        check("rst_flags", {28'h0, zero16, carry16, dz16, out_valid16}, 32'h0);
        check("rst_ready", {30'h0, in_ready16, busy16}, 32'h2);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back single-cycle ops
        drive(16'hFFFF, 16'h0001, 4'h0, 16'h0000, 16'h0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        drive(16'h0003, 16'h0005, 4'h1, 16'hFFFE, 16'h0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        check("ready_after_single", {31'h0, in_ready16}, 32'd1);
        drive(16'hF0F0, 16'hFF00, 4'h2, 16'hF000, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        drive(16'hF0F0, 16'hFF00, 4'h3, 16'hFFF0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        drive(16'hF0F0, 16'hFF00, 4'h4, 16'h0FF0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        drive(16'hF0F0, 16'hFF00, 4'h5, 16'h000F, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        drive(16'hF0F0, 16'hFF00, 4'h7, 16'hF00F, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        wait_idle("idle_logic");

        // MUL with ignored requests while busy; outputs must hold the XNOR result
        drive(16'h1234, 16'h5678, 4'h8, 16'h0060, 16'h0626, 1'b0, 1'b0, 1'b0, 16, 1'b1);
        for (int i = 0; i < 5; i++) begin
            a16 = 16'h0001; b16 = 16'h0001; op16 = 4'h0; iv16 = 1'b1;
            check("busy_mul", {30'h0, in_ready16, busy16}, 32'h1);
            check("hold_mul", {16'h0, result16}, 32'h0000F00F);
            @(negedge clk);
        end
        wait_idle("idle_mul");

        drive(16'd1000, 16'd7, 4'h9, 16'h008E, 16'h0006, 1'b0, 1'b0, 1'b0, 16, 1'b1);
        wait_idle("idle_div");
        drive(16'd5, 16'd0, 4'h9, 16'hFFFF, 16'h0005, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        drive(16'h0001, 16'h0013, 4'h6, 16'h0008, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        drive(16'h8000, 16'h0003, 4'hB, 16'hF000, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        drive(16'h8000, 16'h0003, 4'hA, 16'h1000, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        wait_idle("idle_shift");

        // Reset mid-MUL: aborted silently
        drive(16'h00FF, 16'h00FF, 4'h8, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16, 1'b0);
        iv16 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {result16, result_hi16}, 32'h0);
        check("abort_flags", {28'h0, zero16, carry16, dz16, out_valid16}, 32'h0);
        check("abort_ready", {30'h0, in_ready16, busy16}, 32'h2);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        drive(16'h1234, 16'h5678, 4'hE, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        wait_idle("idle_reserved");

        // WIDTH=8 multiply
        a8 = 8'hFF; b8 = 8'hFF; op8 = 4'h8; iv8 = 1'b1;
        q8.push_back('{16'h0001, 16'h00FE, 1'b0, 1'b0, 1'b0, cyc + 1 + 8});
        @(negedge clk);
        iv8 = 1'b0;
        check("busy8", {31'h0, busy8}, 32'd1);
        wait_idle("idle_mul8");

        check("q16_empty", q16.size(), 32'd0);
        check("q8_empty", q8.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
Parametrised multi-cycle ALU that generalises the team's 16-bit start/busy ALU.
- Adds WIDTH parameterisation, a valid/ready input handshake and an out_valid completion pulse.
- Multiply is iterative shift-add and divide is restoring; both produce a double-width result (high product / remainder).
- Adds status flags and logical/arithmetic right shifts.
- Sits between the datapath operand registers and the writeback stage; one operation in flight at a time.

Parameters:
WIDTH, 16, operand/result width in bits (>=4, power of two)
SHW, $clog2(WIDTH), shift-amount width taken from b[SHW-1:0] (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
a  input  WIDTH  operand A (unsigned unless noted)
b  input  WIDTH  operand B
opcode  input  4  operation select
in_valid  input  1  request valid
in_ready  output  1  block can accept (state IDLE)
out_valid  output  1  one-cycle completion pulse
result  output  WIDTH  primary result (sum, low product, quotient, ...)
result_hi  output  WIDTH  high product / remainder; 0 for other ops
flag_zero  output  1  result == 0
flag_carry  output  1  ADD carry-out / SUB borrow (a<b); 0 otherwise
flag_dz  output  1  divide by zero occurred
busy  output  1  == ~in_ready

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=1, busy=0, out_valid=0, result=0, result_hi=0, all flags=0. Reset mid-operation aborts it silently; no out_valid afterwards.
- Accept: at the rising edge where in_valid && in_ready. a, b and opcode are latched at that edge; later input changes are ignored. in_valid while busy is ignored (not queued).
- Opcodes (single-cycle: registered at the accept edge, out_valid high the next cycle, in_ready stays 1, back-to-back accepts allowed):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 7 XNOR
  - 6 SHL a<<b[SHW-1:0]
  - A SHR logical
  - B SRA arithmetic (a signed)
  - C-F reserved: result=0, result_hi=0, flags 0 except flag_zero=1, out_valid still pulses
- Widths: ADD/SUB results are truncated to WIDTH. flag_carry = bit WIDTH of the (WIDTH+1)-bit sum, or the borrow for SUB.
- 8 MUL (unsigned): state MUL for WIDTH iteration edges, one multiplier bit per edge (shift-add into a 2*WIDTH accumulator).
  - At the WIDTH-th edge after accept: {result_hi,result}=a*b, state returns IDLE, out_valid=1 next cycle.
  - in_ready is 0 for WIDTH cycles.
- 9 DIVU (unsigned restoring): state DIV for WIDTH edges, one quotient bit per edge; result=quotient, result_hi=remainder. Latency WIDTH.
- Divide by zero (b==0, opcode 9): no iteration; completes like a single-cycle op with result=all ones, result_hi=a, flag_dz=1.
- FSM: IDLE -> MUL|DIV on accept of 8/9 (b!=0 for DIV); MUL|DIV -> IDLE when iteration counter reaches WIDTH-1. The counter is cleared on entry.
- out_valid is exactly one cycle per accepted request; there is no output backpressure.
- result, result_hi and flags hold their value until the next completion. They are not updated during iteration; intermediate values must not appear on the outputs.
- flag_zero is evaluated on result only; flag_dz is 0 for all non-DIV ops.

Test Plan:
- Reset: assert rst_n=0 mid-MUL (cycle 5) -> all outputs 0, in_ready=1, no out_valid pulse after release.
- ADD 0xFFFF+0x0001, then SUB 0x0003-0x0005 back-to-back:
  - first op: result=0x0000, flag_zero=1, flag_carry=1
  - second op: result=0xFFFE, flag_carry=1
  - out_valid high on 2 consecutive cycles.
- MUL 0x1234*0x5678 (WIDTH=16) -> after exactly 16 edges: result=0x0060, result_hi=0x0626, single out_valid. in_valid during busy is ignored.
- DIVU 1000/7 -> latency 16: result=142 (0x008E), result_hi=6; then DIVU 5/0 -> next cycle result=0xFFFF, result_hi=5, flag_dz=1.
- Shifts: SHL 0x0001 by b=0x0013 -> 0x0008 (b masked to 4 bits); SRA 0x8000 by 3 -> 0xF000; SHR 0x8000 by 3 -> 0x1000.
- Reserved opcode 0xE -> result=0, flag_zero=1, out_valid pulse. Repeat the MUL test with WIDTH=8: 0xFF*0xFF -> result_hi=0xFE, result=0x01, latency 8.
